// File: rtl/spi_flash_responder.sv
// SPI-mode-3 serial NOR flash responder: decodes READ (0x03) and JEDEC ID (0x9F),
// serving read data from a valid/ready byte port with a one-byte prefetch buffer.
module spi_flash_responder #(
  parameter int          SYNC     = 2,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        mem_valid,
  output logic [23:0] mem_addr,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        underrun,
  output logic [2:0]  state_dbg
);

  // Memory port: mem_valid rises with mem_addr and both hold until the cycle
  // mem_ready is sampled high; mem_valid drops the following cycle. At most one
  // request is outstanding.

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_JEDEC, ST_IGNORE
  } state_t;

  logic [SYNC-1:0] cs_sr, sclk_sr, mosi_sr;
  logic            cs_s, sclk_s, mosi_s, sclk_d;
  logic            cs_low, sclk_rise, sclk_fall;

  generate
    if (SYNC == 1) begin : g_sync1
      always_ff @(posedge clk) begin
        if (reset) begin
          cs_sr   <= 1'b1;
          sclk_sr <= 1'b1;
          mosi_sr <= 1'b0;
        end else begin
          cs_sr   <= spi_cs;
          sclk_sr <= spi_sclk;
          mosi_sr <= spi_mosi;
        end
      end
    end else begin : g_syncn
      always_ff @(posedge clk) begin
        if (reset) begin
          cs_sr   <= {SYNC{1'b1}};
          sclk_sr <= {SYNC{1'b1}};
          mosi_sr <= '0;
        end else begin
          cs_sr   <= {cs_sr[SYNC-2:0], spi_cs};
          sclk_sr <= {sclk_sr[SYNC-2:0], spi_sclk};
          mosi_sr <= {mosi_sr[SYNC-2:0], spi_mosi};
        end
      end
    end
  endgenerate

  assign cs_s      = cs_sr[SYNC-1];
  assign sclk_s    = sclk_sr[SYNC-1];
  assign mosi_s    = mosi_sr[SYNC-1];
  assign cs_low    = ~cs_s;
  assign sclk_rise = cs_low & ~sclk_d & sclk_s;
  assign sclk_fall = cs_low & sclk_d & ~sclk_s;

  state_t      state_q, state_n;
  logic [4:0]  bit_cnt_q, bit_cnt_n;
  logic [22:0] in_shift_q, in_shift_n;
  logic [7:0]  out_shift_q, out_shift_n;
  logic        miso_q, miso_n;
  logic [23:0] addr_q, addr_n;
  logic        mem_valid_q, mem_valid_n;
  logic [23:0] mem_addr_q, mem_addr_n;
  logic [7:0]  buf_q, buf_n;
  logic        buf_full_q, buf_full_n;
  logic        stale_q, stale_n;
  logic        need_req_q, need_req_n;
  logic [1:0]  jedec_idx_q, jedec_idx_n;
  logic        underrun_q, underrun_n;

  logic [23:0] shift_word;
  logic [7:0]  load_byte;
  logic        mem_hit, got_byte;

  assign mem_hit  = mem_valid_q & mem_ready;
  assign got_byte = mem_hit & ~stale_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_d      <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      in_shift_q  <= '0;
      out_shift_q <= 8'hFF;
      miso_q      <= 1'b1;
      addr_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      stale_q     <= 1'b0;
      need_req_q  <= 1'b0;
      jedec_idx_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      sclk_d      <= sclk_s;
      state_q     <= state_n;
      bit_cnt_q   <= bit_cnt_n;
      in_shift_q  <= in_shift_n;
      out_shift_q <= out_shift_n;
      miso_q      <= miso_n;
      addr_q      <= addr_n;
      mem_valid_q <= mem_valid_n;
      mem_addr_q  <= mem_addr_n;
      buf_q       <= buf_n;
      buf_full_q  <= buf_full_n;
      stale_q     <= stale_n;
      need_req_q  <= need_req_n;
      jedec_idx_q <= jedec_idx_n;
      underrun_q  <= underrun_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    bit_cnt_n   = bit_cnt_q;
    in_shift_n  = in_shift_q;
    out_shift_n = out_shift_q;
    miso_n      = miso_q;
    addr_n      = addr_q;
    mem_valid_n = mem_valid_q;
    mem_addr_n  = mem_addr_q;
    buf_n       = buf_q;
    buf_full_n  = buf_full_q;
    stale_n     = stale_q;
    need_req_n  = need_req_q;
    jedec_idx_n = jedec_idx_q;
    underrun_n  = 1'b0;
    shift_word  = {in_shift_q, mosi_s};
    load_byte   = 8'hFF;

    // A returning byte is kept unless its request was orphaned by an abort or underrun.
    if (mem_hit) begin
      mem_valid_n = 1'b0;
      stale_n     = 1'b0;
      if (!stale_q) begin
        buf_n      = mem_rdata;
        buf_full_n = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        miso_n    = 1'b1;
        bit_cnt_n = '0;
        if (cs_low) state_n = ST_CMD;
      end
      ST_CMD: begin
        if (sclk_rise) begin
          in_shift_n = shift_word[22:0];
          bit_cnt_n  = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_n = '0;
            if (shift_word[7:0] == 8'h03) begin
              state_n = ST_ADDR;
            end else if (shift_word[7:0] == 8'h9F) begin
              state_n     = ST_JEDEC;
              jedec_idx_n = '0;
            end else begin
              state_n = ST_IGNORE;
            end
          end
        end
      end
      ST_ADDR: begin
        if (sclk_rise) begin
          in_shift_n = shift_word[22:0];
          bit_cnt_n  = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            state_n    = ST_DATA;
            bit_cnt_n  = '0;
            addr_n     = shift_word;
            buf_full_n = 1'b0;
            need_req_n = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (sclk_rise) bit_cnt_n = {2'b00, bit_cnt_q[2:0] + 3'd1};
        if (sclk_fall) begin
          if (bit_cnt_q[2:0] == 3'd0) begin
            if (got_byte) begin
              load_byte  = mem_rdata;
              buf_full_n = 1'b0;
            end else if (buf_full_q) begin
              load_byte  = buf_q;
              buf_full_n = 1'b0;
            end else begin
              // Byte not here in time: send 0xFF and skip it; any in-flight fetch is now stale.
              load_byte  = 8'hFF;
              underrun_n = 1'b1;
              if (mem_valid_q && !mem_hit) stale_n = 1'b1;
            end
            addr_n      = addr_q + 24'd1;
            need_req_n  = 1'b1;
            miso_n      = load_byte[7];
            out_shift_n = {load_byte[6:0], 1'b1};
          end else begin
            miso_n      = out_shift_q[7];
            out_shift_n = {out_shift_q[6:0], 1'b1};
          end
        end
      end
      ST_JEDEC: begin
        if (sclk_rise) bit_cnt_n = {2'b00, bit_cnt_q[2:0] + 3'd1};
        if (sclk_fall) begin
          if (bit_cnt_q[2:0] == 3'd0) begin
            case (jedec_idx_q)
              2'd0:    load_byte = JEDEC_ID[23:16];
              2'd1:    load_byte = JEDEC_ID[15:8];
              2'd2:    load_byte = JEDEC_ID[7:0];
              default: load_byte = 8'hFF;
            endcase
            if (jedec_idx_q != 2'd3) jedec_idx_n = jedec_idx_q + 2'd1;
            miso_n      = load_byte[7];
            out_shift_n = {load_byte[6:0], 1'b1};
          end else begin
            miso_n      = out_shift_q[7];
            out_shift_n = {out_shift_q[6:0], 1'b1};
          end
        end
      end
      ST_IGNORE: miso_n = 1'b1;
      default:   state_n = ST_IDLE;
    endcase

    // Deselect ends any transaction; an in-flight fetch completes but is discarded.
    if (!cs_low) begin
      state_n    = ST_IDLE;
      miso_n     = 1'b1;
      bit_cnt_n  = '0;
      buf_full_n = 1'b0;
      need_req_n = 1'b0;
      underrun_n = 1'b0;
      if (mem_valid_q && !mem_hit) stale_n = 1'b1;
    end

    if (need_req_n && !mem_valid_q) begin
      mem_valid_n = 1'b1;
      mem_addr_n  = addr_n;
      need_req_n  = 1'b0;
    end
  end

  assign spi_miso  = miso_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign busy      = cs_low;
  assign underrun  = underrun_q;
  assign state_dbg = state_q;

endmodule
